// File: rtl/mpsoc_wb_uart_sync_pkg.sv
// Shared types and parameter helpers for the UART input conditioner.
// The filter state keeps a fixed-width counter so it can live in the package.
package mpsoc_wb_uart_sync_pkg;

  localparam int CNT_MAX_W = 8;

  function automatic int cnt_w(input int filter_len);
    return $clog2(filter_len + 1);
  endfunction

  function automatic bit stages_legal(input int stages);
    return stages >= 2;
  endfunction

  function automatic bit filter_len_legal(input int filter_len);
    return (filter_len >= 1) && (cnt_w(filter_len) <= CNT_MAX_W);
  endfunction

  typedef struct packed {
    logic                 level;
    logic [CNT_MAX_W-1:0] cnt;
  } filt_state_t;

endpackage

// File: rtl/mpsoc_wb_uart_sync_stage.sv
// Multi-bit shift-register synchroniser for asynchronous pins.
// It shifts on every clock edge and clears to the idle level.
module mpsoc_wb_uart_sync_stage #(
  parameter int   WIDTH      = 1,
  parameter int   STAGES     = 2,
  parameter logic INIT_VALUE = 1'b1
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             clr_i,
  input  logic [WIDTH-1:0] dat_i,
  output logic [WIDTH-1:0] dat_o
);

  logic [WIDTH-1:0] sr_q [STAGES];

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int k = 0; k < STAGES; k++) sr_q[k] <= {WIDTH{INIT_VALUE}};
    end else if (clr_i) begin
      for (int k = 0; k < STAGES; k++) sr_q[k] <= {WIDTH{INIT_VALUE}};
    end else begin
      sr_q[0] <= dat_i;
      for (int k = 1; k < STAGES; k++) sr_q[k] <= sr_q[k-1];
    end
  end

  assign dat_o = sr_q[STAGES-1];

endmodule

// File: rtl/mpsoc_wb_uart_sync_filter.sv
// Per-channel synchroniser plus consecutive-sample glitch filter for UART pins.
// Edge and glitch pulses are registered alongside the filtered level.
module mpsoc_wb_uart_sync_filter
  import mpsoc_wb_uart_sync_pkg::*;
#(
  parameter int   WIDTH      = 1,
  parameter int   STAGES     = 2,
  parameter logic INIT_VALUE = 1'b1,
  parameter int   FILTER_LEN = 3
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             stage_clr_i,
  input  logic             sample_en_i,
  input  logic [WIDTH-1:0] async_dat_i,
  output logic [WIDTH-1:0] sync_dat_o,
  output logic [WIDTH-1:0] filt_dat_o,
  output logic [WIDTH-1:0] rise_o,
  output logic [WIDTH-1:0] fall_o,
  output logic [WIDTH-1:0] glitch_o
);

  localparam int CNT_W = cnt_w(FILTER_LEN);
  localparam logic [CNT_MAX_W-1:0] ACCEPT_CNT = CNT_MAX_W'(FILTER_LEN - 1);
  localparam logic [CNT_MAX_W-1:0] CNT_ONE    = CNT_MAX_W'(1);

  if (!stages_legal(STAGES)) begin : g_bad_stages
    $error("mpsoc_wb_uart_sync_filter: STAGES must be >= 2");
  end
  if (!filter_len_legal(FILTER_LEN) || (CNT_W > CNT_MAX_W)) begin : g_bad_filter_len
    $error("mpsoc_wb_uart_sync_filter: FILTER_LEN out of range");
  end

  mpsoc_wb_uart_sync_stage #(
    .WIDTH      (WIDTH),
    .STAGES     (STAGES),
    .INIT_VALUE (INIT_VALUE)
  ) u_sync (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .clr_i  (stage_clr_i),
    .dat_i  (async_dat_i),
    .dat_o  (sync_dat_o)
  );

  for (genvar i = 0; i < WIDTH; i++) begin : g_ch
    filt_state_t st_q;
    logic        rise_q;
    logic        fall_q;
    logic        glitch_q;

    // Clear wins over sampling, so an acceptance on the clear edge is dropped silently.
    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
        st_q     <= '{level: INIT_VALUE, cnt: '0};
        rise_q   <= 1'b0;
        fall_q   <= 1'b0;
        glitch_q <= 1'b0;
      end else if (stage_clr_i) begin
        st_q     <= '{level: INIT_VALUE, cnt: '0};
        rise_q   <= 1'b0;
        fall_q   <= 1'b0;
        glitch_q <= 1'b0;
      end else begin
        rise_q   <= 1'b0;
        fall_q   <= 1'b0;
        glitch_q <= 1'b0;
        if (sample_en_i) begin
          if (sync_dat_o[i] != st_q.level) begin
            if (st_q.cnt == ACCEPT_CNT) begin
              st_q.level <= sync_dat_o[i];
              st_q.cnt   <= '0;
              rise_q     <= sync_dat_o[i];
              fall_q     <= ~sync_dat_o[i];
            end else begin
              st_q.cnt <= st_q.cnt + CNT_ONE;
            end
          end else if (st_q.cnt != '0) begin
            // Level returned before acceptance: drop the pending change.
            st_q.cnt <= '0;
            glitch_q <= 1'b1;
          end
        end
      end
    end

    assign filt_dat_o[i] = st_q.level;
    assign rise_o[i]     = rise_q;
    assign fall_o[i]     = fall_q;
    assign glitch_o[i]   = glitch_q;
  end

endmodule

// File: tb/tb_mpsoc_wb_uart_sync_filter.sv
// Directed and randomized checks of the UART sync/filter block against a
// sample-history reference model.
module tb_mpsoc_wb_uart_sync_filter;

  localparam int   WIDTH      = 4;
  localparam int   STAGES     = 2;
  localparam logic INIT_VALUE = 1'b1;
  localparam int   FILTER_LEN = 3;
  localparam logic [WIDTH-1:0] ONES = {WIDTH{INIT_VALUE}};

  logic             clk_i = 1'b0;
  logic             rst_ni;
  logic             stage_clr_i;
  logic             sample_en_i;
  logic [WIDTH-1:0] async_dat_i;
  logic [WIDTH-1:0] sync_dat_o;
  logic [WIDTH-1:0] filt_dat_o;
  logic [WIDTH-1:0] rise_o;
  logic [WIDTH-1:0] fall_o;
  logic [WIDTH-1:0] glitch_o;

  int n_assert = 0;
  int n_fail   = 0;

  mpsoc_wb_uart_sync_filter #(
    .WIDTH      (WIDTH),
    .STAGES     (STAGES),
    .INIT_VALUE (INIT_VALUE),
    .FILTER_LEN (FILTER_LEN)
  ) dut (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .stage_clr_i (stage_clr_i),
    .sample_en_i (sample_en_i),
    .async_dat_i (async_dat_i),
    .sync_dat_o  (sync_dat_o),
    .filt_dat_o  (filt_dat_o),
    .rise_o      (rise_o),
    .fall_o      (fall_o),
    .glitch_o    (glitch_o)
  );

  // clock / reset
  always #5 clk_i = ~clk_i;

  // reference model: async delay line plus per-channel history of enabled
  // samples since the last acceptance
  logic [WIDTH-1:0] delay_q [$];
  logic             hist_q  [WIDTH][$];
  logic [WIDTH-1:0] lvl_m, rise_m, fall_m, glitch_m;

  task automatic model_reset();
    delay_q.delete();
    for (int k = 0; k < STAGES; k++) delay_q.push_back(ONES);
    for (int c = 0; c < WIDTH; c++) hist_q[c].delete();
    lvl_m    = ONES;
    rise_m   = '0;
    fall_m   = '0;
    glitch_m = '0;
  endtask

  function automatic int trailing_run(input int c);
    int run = 0;
    for (int k = hist_q[c].size() - 1; k >= 0; k--) begin
      if (hist_q[c][k] == lvl_m[c]) break;
      run++;
    end
    return run;
  endfunction

  task automatic model_edge(input logic [WIDTH-1:0] a, input logic en, input logic clr);
    logic [WIDTH-1:0] seen;
    logic             s;
    if (clr) begin
      model_reset();
      return;
    end
    rise_m   = '0;
    fall_m   = '0;
    glitch_m = '0;
    seen     = delay_q[0];
    if (en) begin
      for (int c = 0; c < WIDTH; c++) begin
        s = seen[c];
        if (s != lvl_m[c]) begin
          hist_q[c].push_back(s);
          if (trailing_run(c) >= FILTER_LEN) begin
            lvl_m[c]  = s;
            rise_m[c] = s;
            fall_m[c] = ~s;
            hist_q[c].delete();
          end
        end else begin
          if (hist_q[c].size() > 0 && hist_q[c][hist_q[c].size()-1] != lvl_m[c])
            glitch_m[c] = 1'b1;
          hist_q[c].push_back(s);
        end
      end
    end
    delay_q.push_back(a);
    void'(delay_q.pop_front());
  endtask

  // scoreboard
  task automatic check(input string tag, input logic [WIDTH-1:0] obs, input logic [WIDTH-1:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    check({tag, "_sync"},   sync_dat_o, delay_q[0]);
    check({tag, "_filt"},   filt_dat_o, lvl_m);
    check({tag, "_rise"},   rise_o,     rise_m);
    check({tag, "_fall"},   fall_o,     fall_m);
    check({tag, "_glitch"}, glitch_o,   glitch_m);
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_sync"},   sync_dat_o, ONES);
    check({tag, "_filt"},   filt_dat_o, ONES);
    check({tag, "_rise"},   rise_o,     '0);
    check({tag, "_fall"},   fall_o,     '0);
    check({tag, "_glitch"}, glitch_o,   '0);
  endtask

  // driver
  task automatic step(input logic [WIDTH-1:0] a, input logic en, input logic clr, input string tag);
    async_dat_i = a;
    sample_en_i = en;
    stage_clr_i = clr;
    @(posedge clk_i);
    model_edge(a, en, clr);
    #1;
    check_all(tag);
  endtask

  task automatic settle_high();
    for (int k = 0; k < 8; k++) step(ONES, 1'b1, 1'b0, "settle");
  endtask

  logic [WIDTH-1:0] stagger_tbl [10];
  logic [WIDTH-1:0] rnd_a;
  int               n_fall, n_glitch;

  initial begin
    rst_ni      = 1'b0;
    stage_clr_i = 1'b0;
    sample_en_i = 1'b1;
    async_dat_i = '0;
    model_reset();

    // 1: reset state, then synchroniser latency
    #12;
    check_idle("reset");
    rst_ni = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      step('0, 1'b1, 1'b0, "s1_low");
      if (k == 2) check("s1_sync_after2", sync_dat_o, '0);
    end
    settle_high();

    // 2: single falling edge on channel 0, full latency
    for (int k = 1; k <= 7; k++) begin
      step(4'b1110, 1'b1, 1'b0, "s2");
      check("s2_sync0", {3'b000, sync_dat_o[0]}, {3'b000, (k < 2)});
      check("s2_filt0", {3'b000, filt_dat_o[0]}, {3'b000, (k < 5)});
      check("s2_fall0", {3'b000, fall_o[0]},     {3'b000, (k == 5)});
    end
    settle_high();

    // 3: two-cycle glitch on channel 0
    n_fall = 0; n_glitch = 0;
    for (int k = 0; k < 10; k++) begin
      step((k < 2) ? 4'b1110 : 4'b1111, 1'b1, 1'b0, "s3");
      n_fall   += int'(fall_o[0]);
      n_glitch += int'(glitch_o[0]);
    end
    check("s3_fall_count",   WIDTH'(n_fall),   '0);
    check("s3_glitch_count", WIDTH'(n_glitch), 4'd1);

    // 4: sample strobe every 4th cycle
    n_fall = 0;
    for (int k = 0; k < 16; k++) begin
      step(4'b1110, (k % 4 == 3), 1'b0, "s4");
      n_fall += int'(fall_o[0]);
      check("s4_filt0", {3'b000, filt_dat_o[0]}, {3'b000, (k < 11)});
    end
    check("s4_fall_count", WIDTH'(n_fall), 4'd1);
    settle_high();

    // 5: clear on the acceptance edge, then a full fresh acceptance
    for (int k = 1; k <= 10; k++) begin
      step(4'b1110, 1'b1, (k == 5), "s5");
      if (k == 5) check_idle("s5_clr");
      if (k > 5) check("s5_filt0", {3'b000, filt_dat_o[0]}, {3'b000, (k < 10)});
    end
    settle_high();

    // 6: staggered edges on channels 0/2, glitch on 3
    stagger_tbl = '{4'b1110, 4'b0110, 4'b1010, 4'b1010, 4'b1010,
                    4'b1010, 4'b1010, 4'b1010, 4'b1010, 4'b1010};
    for (int k = 0; k < 10; k++) step(stagger_tbl[k], 1'b1, 1'b0, "s6_stagger");
    settle_high();
    for (int k = 0; k < 4; k++) step('0, 1'b1, 1'b0, "s6_precount");
    rst_ni = 1'b0;
    #1;
    check_idle("s6_rst");
    model_reset();
    #1;
    rst_ni = 1'b1;

    // randomized traffic with occasional clears and a mid-run reset
    rnd_a = ONES;
    for (int n = 0; n < 400; n++) begin
      for (int c = 0; c < WIDTH; c++)
        if ($urandom_range(0, 2) == 0) rnd_a[c] = ~rnd_a[c];
      step(rnd_a, ($urandom_range(0, 3) != 0), ($urandom_range(0, 63) == 0), "rand");
      if (n == 200) begin
        rst_ni = 1'b0;
        #1;
        check_idle("rand_rst");
        model_reset();
        #1;
        rst_ni = 1'b1;
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
